// File: rtl/pc_gen.sv
// pc_gen - fetch program-counter generator.
//
// Picks the next fetch PC by fixed priority: trap vector, execute-stage
// redirect, stall (hold), return-address-stack prediction, then sequential
// increment. It also keeps a circular return-address stack (RAS) and flags
// the first PC fetched after a trap or redirect.
//
// Build option: define PC_RAS_EN to compile in the RAS. Without it, no RAS
// storage exists, call_in/ret_in are ignored and ras_count_out reads 0.
//
// Ports
//   clk            clock, all state on rising edge
//   rst            synchronous active-low reset
//   pc_en          advance enable (low = fetch stall)
//   trap_in        take trap (beats pc_en)
//   redirect_in    branch/jump resolution from execute (beats pc_en)
//   redirect_pc_in redirect target
//   call_in        instruction at pc_out is a call
//   ret_in         instruction at pc_out is a return
//   pc_out         current fetch PC (registered)
//   flush_out      pc_out is the first PC after a trap/redirect (registered)
//   ras_count_out  number of valid RAS entries
module pc_gen #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC_VAL = '0,
    parameter logic [31:0]         TRAP_VEC     = 32'h0000_0100,
    parameter int                  INC          = 4,
    parameter int                  RAS_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pc_en,
    input  logic                           trap_in,
    input  logic                           redirect_in,
    input  logic [PC_WIDTH-1:0]            redirect_pc_in,
    input  logic                           call_in,
    input  logic                           ret_in,
    output logic [PC_WIDTH-1:0]            pc_out,
    output logic                           flush_out,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count_out
);

    localparam int                  CNT_W   = $clog2(RAS_DEPTH + 1);
    localparam logic [PC_WIDTH-1:0] TRAP_PC = PC_WIDTH'(TRAP_VEC);
    localparam logic [PC_WIDTH-1:0] INC_PC  = PC_WIDTH'(INC);

    logic [PC_WIDTH-1:0] pc_seq;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic [PC_WIDTH-1:0] ras_top;
    logic                ras_hit;
    logic                advance;

    // Wraps modulo 2^PC_WIDTH; this is also the return address pushed on a call.
    assign pc_seq  = pc_out + INC_PC;
    // A normal fetch step: the only case in which the RAS may change.
    assign advance = pc_en & ~trap_in & ~redirect_in;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    top_ptr;
    logic [PTR_W-1:0]    top_inc;
    logic [PTR_W-1:0]    top_dec;
    logic [CNT_W-1:0]    ras_cnt;
    logic                ras_nonempty;
    logic                ras_full;
    logic                push;
    logic                pop;
    logic                swap;

    assign ras_nonempty = (ras_cnt != '0);
    assign ras_full     = (ras_cnt == CNT_W'(RAS_DEPTH));
    assign top_inc      = top_ptr + PTR_W'(1);
    assign top_dec      = top_ptr - PTR_W'(1);

    // call+ret on an empty stack degenerates to a plain push; on a non-empty
    // stack it predicts from the old top and overwrites it in place.
    assign push = advance & call_in & (~ret_in | ~ras_nonempty);
    assign pop  = advance & ret_in & ~call_in & ras_nonempty;
    assign swap = advance & call_in & ret_in & ras_nonempty;

    assign ras_hit = ret_in & ras_nonempty;
    assign ras_top = ras_mem[top_ptr];

    // Entry storage carries no reset; contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[top_inc] <= pc_seq;
        end else if (swap) begin
            ras_mem[top_ptr] <= pc_seq;
        end
    end

    // Circular pointer: a push when full simply laps onto the oldest entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            top_ptr <= '0;
            ras_cnt <= '0;
        end else if (push) begin
            top_ptr <= top_inc;
            if (!ras_full) begin
                ras_cnt <= ras_cnt + CNT_W'(1);
            end
        end else if (pop) begin
            top_ptr <= top_dec;
            ras_cnt <= ras_cnt - CNT_W'(1);
        end
    end

    assign ras_count_out = ras_cnt;
`else
    logic ras_unused;

    assign ras_unused    = &{1'b0, call_in, ret_in};
    assign ras_hit       = 1'b0;
    assign ras_top       = '0;
    assign ras_count_out = '0;
`endif

    // Next-PC priority mux.
    always_comb begin
        pc_nxt = pc_seq;
        if (trap_in) begin
            pc_nxt = TRAP_PC;
        end else if (redirect_in) begin
            pc_nxt = redirect_pc_in;
        end else if (!pc_en) begin
            pc_nxt = pc_out;
        end else if (ras_hit) begin
            pc_nxt = ras_top;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_out    <= RESET_PC_VAL;
            flush_out <= 1'b0;
        end else begin
            pc_out    <= pc_nxt;
            flush_out <= trap_in | redirect_in;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen (PC_WIDTH=32, TRAP_VEC=0x100, INC=4, RAS_DEPTH=4).
// RAS-dependent expectations follow whether PC_RAS_EN is defined.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en;
    logic        trap_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        call_in;
    logic        ret_in;
    logic [31:0] pc_out;
    logic        flush_out;
    logic [2:0]  ras_count_out;

    int total = 0;
    int bad   = 0;

    pc_gen #(
        .PC_WIDTH    (32),
        .RESET_PC_VAL(32'h0),
        .TRAP_VEC    (32'h0000_0100),
        .INC         (4),
        .RAS_DEPTH   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_en         (pc_en),
        .trap_in       (trap_in),
        .redirect_in   (redirect_in),
        .redirect_pc_in(redirect_pc_in),
        .call_in       (call_in),
        .ret_in        (ret_in),
        .pc_out        (pc_out),
        .flush_out     (flush_out),
        .ras_count_out (ras_count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] pc, input logic fl,
                          input logic [2:0] cnt);
        chk({tag, ".pc"}, pc_out, pc);
        chk({tag, ".flush"}, {31'd0, flush_out}, {31'd0, fl});
        chk({tag, ".cnt"}, {29'd0, ras_count_out}, {29'd0, cnt});
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_in = 1'b1; redirect_pc_in = pc;
        step();
        redirect_in = 1'b0;
    endtask

    initial begin
        rst = 1'b0; pc_en = 1'b0; trap_in = 1'b0; redirect_in = 1'b0;
        redirect_pc_in = '0; call_in = 1'b0; ret_in = 1'b0;

        // Reset, with noise on the other inputs that must be overridden.
        trap_in = 1'b1; call_in = 1'b1;
        step();
        chk_pc("reset", 32'h0, 1'b0, 3'd0);
        trap_in = 1'b0; call_in = 1'b0;

        // Sequential fetch.
        rst = 1'b1; pc_en = 1'b1;
        step(); chk_pc("seq1", 32'h4, 1'b0, 3'd0);
        step(); chk_pc("seq2", 32'h8, 1'b0, 3'd0);
        step(); chk_pc("seq3", 32'hC, 1'b0, 3'd0);

        // Redirect and trap beat a stall; trap beats redirect.
        pc_en = 1'b0;
        redirect_in = 1'b1; redirect_pc_in = 32'h2000;
        step(); chk_pc("redir_stall", 32'h2000, 1'b1, 3'd0);
        trap_in = 1'b1;
        step(); chk_pc("trap_over_redir", 32'h100, 1'b1, 3'd0);
        trap_in = 1'b0; redirect_in = 1'b0;
        step(); chk_pc("stall_hold", 32'h100, 1'b0, 3'd0);

        // Call, redirect away, return.
        redirect_to(32'h10);
        pc_en = 1'b1; call_in = 1'b1;
        step(); call_in = 1'b0;
`ifdef PC_RAS_EN
        chk_pc("call", 32'h14, 1'b0, 3'd1);
        redirect_to(32'h400);
        chk_pc("call_redir", 32'h400, 1'b1, 3'd1);
        ret_in = 1'b1;
        step(); ret_in = 1'b0;
        chk_pc("ret", 32'h14, 1'b0, 3'd0);

        // Five calls saturate the count and overwrite the oldest entry.
        redirect_to(32'h0);
        call_in = 1'b1;
        step(); chk_pc("push1", 32'h4,  1'b0, 3'd1);
        step(); chk_pc("push2", 32'h8,  1'b0, 3'd2);
        step(); chk_pc("push3", 32'hC,  1'b0, 3'd3);
        step(); chk_pc("push4", 32'h10, 1'b0, 3'd4);
        step(); chk_pc("push5", 32'h14, 1'b0, 3'd4);
        call_in = 1'b0; ret_in = 1'b1;
        step(); chk_pc("pop1", 32'h14, 1'b0, 3'd3);
        step(); chk_pc("pop2", 32'h10, 1'b0, 3'd2);
        step(); chk_pc("pop3", 32'hC,  1'b0, 3'd1);
        step(); chk_pc("pop4", 32'h8,  1'b0, 3'd0);
        step(); chk_pc("pop_empty", 32'hC, 1'b0, 3'd0);

        // call+ret on a non-empty stack swaps the top entry in place.
        ret_in = 1'b0; call_in = 1'b1;
        step(); chk_pc("push_a", 32'h10, 1'b0, 3'd1);
        ret_in = 1'b1;
        step(); chk_pc("swap", 32'h10, 1'b0, 3'd1);
        call_in = 1'b0;
        step(); chk_pc("pop_swapped", 32'h14, 1'b0, 3'd0);
        ret_in = 1'b0;

        // Stalled call leaves the RAS alone.
        pc_en = 1'b0; call_in = 1'b1;
        step(); chk_pc("stall_call", 32'h14, 1'b0, 3'd0);
        pc_en = 1'b1; call_in = 1'b0;
`else
        chk_pc("call_off", 32'h14, 1'b0, 3'd0);
        ret_in = 1'b1;
        step(); ret_in = 1'b0;
        chk_pc("ret_off", 32'h18, 1'b0, 3'd0);
        call_in = 1'b1; ret_in = 1'b1;
        step(); chk_pc("callret_off", 32'h1C, 1'b0, 3'd0);
        call_in = 1'b0; ret_in = 1'b0;
`endif

        // Address wrap.
        redirect_to(32'hFFFF_FFFC);
        step(); chk_pc("wrap", 32'h0, 1'b0, 3'd0);

        // Reset in the middle of a return with two entries stacked.
        call_in = 1'b1;
        step(); step();
        call_in = 1'b0;
`ifdef PC_RAS_EN
        chk_pc("pre_rst", 32'h8, 1'b0, 3'd2);
`else
        chk_pc("pre_rst", 32'h8, 1'b0, 3'd0);
`endif
        ret_in = 1'b1; rst = 1'b0;
        step(); chk_pc("mid_rst", 32'h0, 1'b0, 3'd0);
        rst = 1'b1; ret_in = 1'b0;
        step(); chk_pc("post_rst", 32'h4, 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
